// File: rtl/p_mul_pkg.sv
// Shared types and helpers for the parametrised sequential packed multiplier.
package p_mul_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    localparam logic [4:0] PwFull      = 5'b00001;
    localparam logic [4:0] PwHalf      = 5'b00010;
    localparam logic [4:0] PwQuarter   = 5'b00100;
    localparam logic [4:0] PwEighth    = 5'b01000;
    localparam logic [4:0] PwSixteenth = 5'b10000;

    localparam int unsigned NumWidths = 5;

    // Lane width W = XLEN >> index; the lowest set bit wins and an all-zero select means full width.
    function automatic logic [2:0] pw_index(input logic [4:0] pw);
        if (|(pw & PwFull))           return 3'd0;
        else if (|(pw & PwHalf))      return 3'd1;
        else if (|(pw & PwQuarter))   return 3'd2;
        else if (|(pw & PwEighth))    return 3'd3;
        else if (|(pw & PwSixteenth)) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [5:0] pw_log2w(input logic [4:0] pw, input int unsigned log2_xlen);
        return 6'(log2_xlen) - 6'(pw_index(pw));
    endfunction

    function automatic bit bps_legal(input int unsigned bps);
        return (bps == 1) || (bps == 2) || (bps == 4);
    endfunction

    function automatic int unsigned bps_log2(input int unsigned bps);
        return (bps == 4) ? 2 : ((bps == 2) ? 1 : 0);
    endfunction

endpackage

// File: rtl/p_mul_step.sv
// One iteration of the lane-masked shift-add / shift-xor recurrence for every lane width;
// the active width selects which candidate partial sum is used.
module p_mul_step
    import p_mul_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPS  = 1
) (
    input  logic [2*XLEN-1:0] ps_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   mplr_i,
    input  logic [5:0]        log2w_i,
    input  logic              clmul_i,
    output logic [2*XLEN-1:0] ps_o
);
    localparam int unsigned Log2Xlen = $clog2(XLEN);

    logic [NumWidths*2*XLEN-1:0] ps_all;

    for (genvar k = 0; k < NumWidths; k++) begin : gen_width
        localparam int unsigned W     = XLEN >> k;
        // Narrow lanes retire at most W bits per step, so the whole product takes one step.
        localparam int unsigned E     = (BPS < W) ? BPS : W;
        localparam int unsigned Lanes = 1 << k;

        logic [2*XLEN-1:0] nxt;

        always_comb begin
            logic [2*W+E-1:0] acc;
            logic [2*W+E-1:0] term;
            nxt  = '0;
            acc  = '0;
            term = '0;
            for (int l = 0; l < Lanes; l++) begin
                acc = {{E{1'b0}}, ps_i[l*2*W +: 2*W]};
                for (int j = 0; j < E; j++) begin
                    term = {{E{1'b0}}, rs1_i[l*W +: W], {W{1'b0}}} << j;
                    if (mplr_i[l*W + j]) begin
                        acc = clmul_i ? (acc ^ term) : (acc + term);
                    end
                end
                // Dropping the low E bits is the per-lane right shift; carries stay in the lane.
                nxt[l*2*W +: 2*W] = acc[E +: 2*W];
            end
        end

        assign ps_all[k*2*XLEN +: 2*XLEN] = nxt;
    end

    always_comb begin
        ps_o = ps_all[2*XLEN-1:0];
        for (int unsigned k = 0; k < NumWidths; k++) begin
            if (log2w_i == 6'(Log2Xlen - k)) begin
                ps_o = ps_all[k*2*XLEN +: 2*XLEN];
            end
        end
    end

    // Only the low slice of each lane is consumed; higher bits arrive via the per-step shift.
    logic unused_mplr;
    assign unused_mplr = ^mplr_i;

endmodule

// File: rtl/p_mul_seq.sv
// Sequential packed multiplier (integer or carry-less, low or high half) with
// valid/ready handshakes on both sides and synchronous flush.
module p_mul_seq
    import p_mul_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPS  = 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_hi,
    input  logic            in_clmul,
    input  logic [4:0]      in_pw,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);
    localparam int unsigned Log2Xlen = $clog2(XLEN);
    localparam int unsigned Log2Bps  = bps_log2(BPS);
    localparam int unsigned StepW    = $clog2(XLEN);

    if (!bps_legal(BPS)) begin : gen_bad_bps
        $error("p_mul_seq: BPS must be 1, 2 or 4");
    end
    if ((XLEN < 32) || ((XLEN & (XLEN - 1)) != 0)) begin : gen_bad_xlen
        $error("p_mul_seq: XLEN must be a power of two, at least 32");
    end

    state_e            state_q, state_d;
    logic [StepW-1:0]  step_q, step_d, step_last_idx;
    logic [2*XLEN-1:0] ps_q, ps_d, ps_nxt;
    logic [XLEN-1:0]   rs1_q, rs1_d, mplr_q, mplr_d, result;
    logic [5:0]        log2w_q, log2w_d;
    logic              hi_q, hi_d, clmul_q, clmul_d;
    logic              accept, step_last;

    assign accept = in_valid & in_ready & ~flush;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (in_valid) state_d = StBusy;
                StBusy:  if (step_last) state_d = StDone;
                StDone:  if (out_ready) state_d = in_valid ? StBusy : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_result = '0;
        case (state_q)
            StIdle: in_ready = 1'b1;
            StDone: begin
                in_ready   = out_ready;
                out_valid  = 1'b1;
                out_result = result;
            end
            default: ;
        endcase
    end

    // Last step index is W/E - 1 where E = min(BPS, W).
    always_comb begin
        if (int'(log2w_q) <= int'(Log2Bps)) begin
            step_last_idx = '0;
        end else begin
            step_last_idx = StepW'((32'd1 << (log2w_q - 6'(Log2Bps))) - 32'd1);
        end
    end
    assign step_last = (step_q == step_last_idx);

    always_comb begin
        rs1_d   = rs1_q;
        mplr_d  = mplr_q;
        hi_d    = hi_q;
        clmul_d = clmul_q;
        log2w_d = log2w_q;
        ps_d    = ps_q;
        step_d  = step_q;
        if (flush) begin
            step_d = '0;
        end else if (accept) begin
            rs1_d   = in_rs1;
            mplr_d  = in_rs2;
            hi_d    = in_hi;
            clmul_d = in_clmul;
            log2w_d = pw_log2w(in_pw, Log2Xlen);
            ps_d    = '0;
            step_d  = '0;
        end else if (state_q == StBusy) begin
            ps_d   = ps_nxt;
            // A whole-word shift is safe: each lane only reads its low bits before they run out.
            mplr_d = mplr_q >> BPS;
            step_d = step_last ? '0 : step_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rs1_q   <= '0;
            mplr_q  <= '0;
            hi_q    <= 1'b0;
            clmul_q <= 1'b0;
            log2w_q <= 6'(Log2Xlen);
            ps_q    <= '0;
            step_q  <= '0;
        end else begin
            rs1_q   <= rs1_d;
            mplr_q  <= mplr_d;
            hi_q    <= hi_d;
            clmul_q <= clmul_d;
            log2w_q <= log2w_d;
            ps_q    <= ps_d;
            step_q  <= step_d;
        end
    end

    p_mul_step #(
        .XLEN (XLEN),
        .BPS  (BPS)
    ) u_step (
        .ps_i    (ps_q),
        .rs1_i   (rs1_q),
        .mplr_i  (mplr_q),
        .log2w_i (log2w_q),
        .clmul_i (clmul_q),
        .ps_o    (ps_nxt)
    );

    logic [NumWidths*XLEN-1:0] res_all;

    for (genvar k = 0; k < NumWidths; k++) begin : gen_res
        localparam int unsigned W = XLEN >> k;
        for (genvar l = 0; l < (1 << k); l++) begin : gen_lane
            assign res_all[k*XLEN + l*W +: W] = hi_q ? ps_q[l*2*W + W +: W] : ps_q[l*2*W +: W];
        end
    end

    always_comb begin
        result = res_all[XLEN-1:0];
        for (int unsigned k = 0; k < NumWidths; k++) begin
            if (log2w_q == 6'(Log2Xlen - k)) begin
                result = res_all[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: tb/tb_p_mul_seq.sv
// Bench for p_mul_seq: three instances at BPS = 1, 2, 4 checked against a lane-wise
// arithmetic reference model.
module tb_p_mul_seq;
    localparam int NDut = 3;

    logic        clock;
    logic        resetn;
    logic        flush      [NDut];
    logic        in_valid   [NDut];
    logic        in_ready   [NDut];
    logic        in_hi      [NDut];
    logic        in_clmul   [NDut];
    logic [4:0]  in_pw      [NDut];
    logic [31:0] in_rs1     [NDut];
    logic [31:0] in_rs2     [NDut];
    logic        out_valid  [NDut];
    logic        out_ready  [NDut];
    logic [31:0] out_result [NDut];

    int checks;
    int errors;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < NDut; g++) begin : gen_dut
        p_mul_seq #(
            .XLEN (32),
            .BPS  (1 << g)
        ) u_dut (
            .clock      (clock),
            .resetn     (resetn),
            .flush      (flush[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_hi      (in_hi[g]),
            .in_clmul   (in_clmul[g]),
            .in_pw      (in_pw[g]),
            .in_rs1     (in_rs1[g]),
            .in_rs2     (in_rs2[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_result (out_result[g])
        );
    end

    typedef struct packed {
        logic [1:0]  d;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  pw;
        logic        hi;
        logic        cl;
        logic [31:0] exp;
        logic [5:0]  lat;
    } vec_t;

    function automatic int ref_width(input logic [4:0] pw);
        int w;
        w = 32;
        for (int i = 4; i >= 0; i--) if (pw[i]) w = 32 >> i;
        return w;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] pw, input logic hi, input logic cl);
        int w;
        longint unsigned mask, x, y, p;
        logic [31:0] r;
        w    = ref_width(pw);
        mask = (64'd1 << w) - 64'd1;
        r    = '0;
        for (int l = 0; l < 32 / w; l++) begin
            x = (64'(a) >> (l * w)) & mask;
            y = (64'(b) >> (l * w)) & mask;
            if (!cl) begin
                p = x * y;
            end else begin
                p = 0;
                for (int j = 0; j < w; j++) if (((y >> j) & 64'd1) != 0) p = p ^ (x << j);
            end
            if (hi) p = p >> w;
            r = r | (32'(p & mask) << (l * w));
        end
        return r;
    endfunction

    function automatic int ref_lat(input logic [4:0] pw, input int bps);
        int w;
        w = ref_width(pw);
        return (w > bps) ? (w / bps) : 1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input int d, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] pw, input logic hi, input logic cl);
        in_rs1[d]   = a;
        in_rs2[d]   = b;
        in_pw[d]    = pw;
        in_hi[d]    = hi;
        in_clmul[d] = cl;
        in_valid[d] = 1'b1;
    endtask

    task automatic wait_valid(input int d, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!out_valid[d] && cnt < 200);
    endtask

    // Present a request, take the accept edge, then wait for the result.
    task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] pw, input logic hi, input logic cl,
                          output logic rdy, output logic [31:0] res, output int cnt);
        present(d, a, b, pw, hi, cl);
        #1;
        rdy = in_ready[d];
        tick();
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        in_rs1[d]    = $urandom;
        in_rs2[d]    = $urandom;
        wait_valid(d, cnt);
        res = out_result[d];
    endtask

    task automatic consume(input int d);
        out_ready[d] = 1'b1;
        tick();
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < NDut; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_result[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset[%0d]: got ready=%b valid=%b result=%h, expected 1 0 00000000",
                         d, in_ready[d], out_valid[d], out_result[d]);
            end
        end
        #3 resetn = 1'b1;
        tick();
        for (int d = 0; d < NDut; d++) begin
            checks++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset[%0d]: got ready=%b valid=%b, expected 1 0",
                         d, in_ready[d], out_valid[d]);
            end
        end
    endtask

    task automatic test_directed();
        vec_t v [12];
        logic rdy;
        logic [31:0] res;
        int cnt;
        v[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b0, 1'b0, 32'h00000001, 6'd32};
        v[1]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b00001, 1'b1, 1'b0, 32'hFFFFFFFE, 6'd32};
        v[2]  = '{2'd0, 32'h03FF1080, 32'h05FF1002, 5'b00100, 1'b0, 1'b0, 32'h0F010000, 6'd8};
        v[3]  = '{2'd0, 32'h03FF1080, 32'h05FF1002, 5'b00100, 1'b1, 1'b0, 32'h00FE0101, 6'd8};
        v[4]  = '{2'd1, 32'h03FF1080, 32'h05FF1002, 5'b00100, 1'b0, 1'b0, 32'h0F010000, 6'd4};
        v[5]  = '{2'd2, 32'h03FF1080, 32'h05FF1002, 5'b00100, 1'b1, 1'b0, 32'h00FE0101, 6'd2};
        v[6]  = '{2'd0, 32'h00000003, 32'h00000003, 5'b00001, 1'b0, 1'b1, 32'h00000005, 6'd32};
        v[7]  = '{2'd0, 32'h80000000, 32'h80000000, 5'b00001, 1'b1, 1'b1, 32'h40000000, 6'd32};
        v[8]  = '{2'd0, 32'h80000000, 32'h80000000, 5'b00001, 1'b0, 1'b1, 32'h00000000, 6'd32};
        v[9]  = '{2'd1, 32'h12345678, 32'h00000010, 5'b00000, 1'b0, 1'b0, 32'h23456780, 6'd16};
        v[10] = '{2'd0, 32'h00020003, 32'h00040005, 5'b10110, 1'b0, 1'b0, 32'h0008000F, 6'd16};
        v[11] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'b10000, 1'b1, 1'b0, 32'hAAAAAAAA, 6'd1};
        for (int i = 0; i < 12; i++) begin
            run_op(int'(v[i].d), v[i].a, v[i].b, v[i].pw, v[i].hi, v[i].cl, rdy, res, cnt);
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL directed[%0d] ready: got %b expected 1", i, rdy);
            end
            checks++;
            if (cnt != int'(v[i].lat)) begin
                errors++;
                $display("FAIL directed[%0d] latency: got %0d expected %0d", i, cnt, v[i].lat);
            end
            checks++;
            if (res !== v[i].exp) begin
                errors++;
                $display("FAIL directed[%0d] result: got %h expected %h", i, res, v[i].exp);
            end
            consume(int'(v[i].d));
            checks++;
            if (out_valid[v[i].d] !== 1'b0) begin
                errors++;
                $display("FAIL directed[%0d] drop_valid: got %b expected 0", i, out_valid[v[i].d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, exp, res;
        logic rdy;
        int cnt;
        a   = $urandom;
        b   = $urandom;
        exp = ref_mul(a, b, 5'b00010, 1'b1, 1'b0);
        run_op(0, a, b, 5'b00010, 1'b1, 1'b0, rdy, res, cnt);
        checks++;
        if (res !== exp || cnt != 16) begin
            errors++;
            $display("FAIL bp_first: got %h after %0d, expected %h after 16", res, cnt, exp);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid[0] !== 1'b1 || out_result[0] !== exp || in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b result=%h ready=%b, expected 1 %h 0",
                         i, out_valid[0], out_result[0], in_ready[0], exp);
            end
        end
        a   = $urandom;
        b   = $urandom;
        exp = ref_mul(a, b, 5'b00100, 1'b0, 1'b0);
        out_ready[0] = 1'b1;
        run_op(0, a, b, 5'b00100, 1'b0, 1'b0, rdy, res, cnt);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b expected 1", rdy);
        end
        checks++;
        if (cnt != 8 || res !== exp) begin
            errors++;
            $display("FAIL b2b_result: got %h after %0d, expected %h after 8", res, cnt, exp);
        end
        consume(0);
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic rdy;
        int cnt;
        bit saw;
        present(0, $urandom, $urandom, 5'b00001, 1'b0, 1'b0);
        #1;
        tick();
        in_valid[0] = 1'b0;
        repeat (5) tick();
        flush[0] = 1'b1;
        present(0, 32'hA, 32'hB, 5'b00001, 1'b0, 1'b0);
        tick();
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy: got valid=%b ready=%b, expected 0 1", out_valid[0], in_ready[0]);
        end
        saw = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid[0]) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL flush_orphan: got out_valid=1 expected none");
        end
        run_op(0, 32'd7, 32'd6, 5'b00001, 1'b0, 1'b0, rdy, res, cnt);
        checks++;
        if (rdy !== 1'b1 || res !== 32'd42 || cnt != 32) begin
            errors++;
            $display("FAIL flush_next: got %0d after %0d ready=%b, expected 42 after 32 ready=1",
                     res, cnt, rdy);
        end
        consume(0);
        // Flush while DONE with a simultaneous accept: the accept must be dropped.
        run_op(1, $urandom, $urandom, 5'b00100, 1'b0, 1'b0, rdy, res, cnt);
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL flush_done_lat: got %0d expected 4", cnt);
        end
        out_ready[1] = 1'b1;
        flush[1]     = 1'b1;
        present(1, 32'h5, 32'h5, 5'b00001, 1'b0, 1'b0);
        tick();
        flush[1]     = 1'b0;
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        checks++;
        if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: got valid=%b ready=%b, expected 0 1", out_valid[1], in_ready[1]);
        end
        saw = 1'b0;
        repeat (20) begin
            tick();
            if (out_valid[1]) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL flush_done_orphan: got out_valid=1 expected none");
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        logic rdy;
        int cnt;
        bit saw;
        present(0, 32'h1234, 32'h5678, 5'b00001, 1'b0, 1'b0);
        #1;
        tick();
        in_valid[0] = 1'b0;
        repeat (3) tick();
        #3 resetn = 1'b0;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_result[0] !== 32'h0) begin
            errors++;
            $display("FAIL rst_busy: got ready=%b valid=%b result=%h, expected 1 0 00000000",
                     in_ready[0], out_valid[0], out_result[0]);
        end
        #1 resetn = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid[0]) saw = 1'b1;
        end
        checks++;
        if (saw || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_after: got saw_valid=%b ready=%b, expected 0 1", saw, in_ready[0]);
        end
        run_op(0, 32'h000000FF, 32'h00000003, 5'b00100, 1'b0, 1'b0, rdy, res, cnt);
        checks++;
        if (out_valid[0] !== 1'b1 || res !== 32'h000000FD) begin
            errors++;
            $display("FAIL rst_done_pre: got valid=%b result=%h, expected 1 000000fd",
                     out_valid[0], res);
        end
        #3 resetn = 1'b0;
        #1;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_result[0] !== 32'h0) begin
            errors++;
            $display("FAIL rst_done: got ready=%b valid=%b result=%h, expected 1 0 00000000",
                     in_ready[0], out_valid[0], out_result[0]);
        end
        #1 resetn = 1'b1;
        tick();
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: got ready=%b valid=%b, expected 1 0", in_ready[0], out_valid[0]);
        end
    endtask

    task automatic test_random(input int d, input int n);
        logic [31:0] a, b, exp, res;
        logic [4:0] pw;
        logic hi, cl, rdy;
        int cnt, lat;
        bit pending;
        pending = 1'b0;
        for (int i = 0; i < n; i++) begin
            a   = $urandom;
            b   = $urandom;
            pw  = 5'($urandom);
            hi  = 1'($urandom);
            cl  = 1'($urandom);
            exp = ref_mul(a, b, pw, hi, cl);
            lat = ref_lat(pw, 1 << d);
            if (pending && ($urandom_range(0, 1) == 0)) begin
                consume(d);
                pending = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            if (pending) out_ready[d] = 1'b1;
            run_op(d, a, b, pw, hi, cl, rdy, res, cnt);
            checks++;
            if (rdy !== 1'b1 || cnt != lat || res !== exp) begin
                errors++;
                $display("FAIL rand[%0d.%0d] pw=%b hi=%b cl=%b a=%h b=%h: got %h after %0d ready=%b, expected %h after %0d",
                         d, i, pw, hi, cl, a, b, res, cnt, rdy, exp, lat);
            end
            repeat ($urandom_range(0, 3)) begin
                tick();
                checks++;
                if (out_valid[d] !== 1'b1 || out_result[d] !== exp) begin
                    errors++;
                    $display("FAIL rand_stall[%0d.%0d]: got valid=%b result=%h, expected 1 %h",
                             d, i, out_valid[d], out_result[d], exp);
                end
            end
            pending = 1'b1;
        end
        consume(d);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        for (int d = 0; d < NDut; d++) begin
            flush[d]     = 1'b0;
            in_valid[d]  = 1'b0;
            in_hi[d]     = 1'b0;
            in_clmul[d]  = 1'b0;
            in_pw[d]     = 5'b00001;
            in_rs1[d]    = '0;
            in_rs2[d]    = '0;
            out_ready[d] = 1'b0;
        end
        repeat (2) tick();
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_async_reset();
        for (int d = 0; d < NDut; d++) test_random(d, 40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
